// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - leaky integrate-and-fire neuron core; optional leak via NEURON_LEAK_EN
module lif_neuron_core #(
    parameter int SUM_W      = 10,
    parameter int MEM_W      = 16,
    parameter int THRESH     = 512,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_cout,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic             spike,
    output logic [MEM_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_FIRE   = 2'd2,
        S_REFRAC = 2'd3
    } state_t;

    // Counter must hold REFRAC_CYC; keep at least one bit when refractory is disabled.
    localparam int CNT_W = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
    localparam logic [MEM_W-1:0] THRESH_V = MEM_W'(THRESH);
    localparam logic [CNT_W-1:0] REFRAC_V = CNT_W'(REFRAC_CYC);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] refrac_cnt;
    logic [MEM_W:0]   operand;
    logic [MEM_W-1:0] mem_base;
    logic [MEM_W:0]   mem_sum;
    logic [MEM_W-1:0] mem_sat;
    logic             xfer;

    // Tree result is SUM_W+1 bits with the carry as MSB, zero-extended to MEM_W+1.
    assign operand = {{(MEM_W - SUM_W){1'b0}}, sum_cout, sum_in};

`ifdef NEURON_LEAK_EN
    // Leak comes from the pre-update membrane; it never exceeds mem_out, so no underflow.
    assign mem_base = mem_out - (mem_out >> LEAK_SHIFT);
`else
    assign mem_base = mem_out;
`endif

    // One extra bit catches overflow; clamp to full scale instead of wrapping.
    assign mem_sum = {1'b0, mem_base} + operand;
    assign mem_sat = mem_sum[MEM_W] ? {MEM_W{1'b1}} : mem_sum[MEM_W-1:0];
    assign xfer    = sum_valid & sum_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: integrate, check, fire, then sit out the refractory period.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (xfer) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (mem_out >= THRESH_V) ? S_FIRE : S_IDLE;
            S_FIRE:   state_nxt = (REFRAC_CYC == 0) ? S_IDLE : S_REFRAC;
            S_REFRAC: if (refrac_cnt <= CNT_W'(1)) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic: only IDLE accepts a new sum.
    always_comb begin
        sum_ready = 1'b0;
        if (state == S_IDLE) sum_ready = 1'b1;
    end

    // Membrane, spike pulse and refractory counter; spike registers the FIRE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out    <= '0;
            spike      <= 1'b0;
            refrac_cnt <= '0;
        end else begin
            spike <= (state == S_FIRE);
            if (xfer) begin
                mem_out <= mem_sat;
            end else if (state == S_FIRE) begin
                mem_out <= '0;
            end
            if (state == S_FIRE) begin
                refrac_cnt <= REFRAC_V;
            end else if (state == S_REFRAC && refrac_cnt != '0) begin
                refrac_cnt <= refrac_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb/tb_lif_neuron_core.sv - self-checking bench for lif_neuron_core (default and saturation instances)
module tb_lif_neuron_core;

    logic        clk;
    logic        rst_n;
    logic [9:0]  s_in  [2];
    logic        s_c   [2];
    logic        s_v   [2];
    logic        rdy   [2];
    logic        spk   [2];
    logic [15:0] mo    [2];

    int n_assert = 0;
    int n_fail   = 0;
    int m_model [2];
    int th      [2] = '{512, 65535};
    int rf      [2] = '{3, 0};

    lif_neuron_core dut0 (
        .clk(clk), .rst_n(rst_n),
        .sum_in(s_in[0]), .sum_cout(s_c[0]), .sum_valid(s_v[0]),
        .sum_ready(rdy[0]), .spike(spk[0]), .mem_out(mo[0])
    );

    lif_neuron_core #(.THRESH(65535), .REFRAC_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .sum_in(s_in[1]), .sum_cout(s_c[1]), .sum_valid(s_v[1]),
        .sum_ready(rdy[1]), .spike(spk[1]), .mem_out(mo[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_step(input int m, input int in);
        int leak;
        int r;
        leak = 0;
`ifdef NEURON_LEAK_EN
        leak = m / 16;
`endif
        r = m - leak + in;
        if (r > 65535) r = 65535;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int w, input int val);
        int waits;
        logic [10:0] v;
        waits = 0;
        v = val[10:0];
        while (rdy[w] !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("ready_wait", 32'(waits < 50), 1);
        s_in[w] = v[9:0];
        s_c[w]  = v[10];
        s_v[w]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_v[w] = 1'b0;
        m_model[w] = model_step(m_model[w], val);
        check("mem_after_xfer", mo[w], m_model[w]);
        check("ready_in_check", rdy[w], 0);
        check("spike_in_check", spk[w], 0);
        if (m_model[w] >= th[w]) begin
            @(negedge clk);
            check("fire_ready", rdy[w], 0);
            check("fire_spike_early", spk[w], 0);
            check("fire_mem_held", mo[w], m_model[w]);
            @(negedge clk);
            check("spike_pulse", spk[w], 1);
            check("mem_cleared", mo[w], 0);
            for (int i = 0; i < rf[w]; i++) begin
                check("refrac_ready", rdy[w], 0);
                if (i > 0) check("spike_width", spk[w], 0);
                @(negedge clk);
            end
            check("ready_after_refrac", rdy[w], 1);
            check("spike_after_refrac", spk[w], 32'(rf[w] == 0));
            m_model[w] = 0;
        end else begin
            @(negedge clk);
            check("ready_no_spike", rdy[w], 1);
            check("spike_none", spk[w], 0);
            check("mem_hold", mo[w], m_model[w]);
        end
    endtask

    initial begin
        int low;
        int val;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_in[i] = '0;
            s_c[i]  = 1'b0;
            s_v[i]  = 1'b0;
            m_model[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_mem", mo[i], 0);
            check("reset_spike", spk[i], 0);
            check("reset_ready", rdy[i], 1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry-out only: operand 1024 crosses threshold straight from reset.
        send(0, 1024);
        // Two integrations, second one crosses.
        send(0, 300);
        send(0, 300);

        // Valid held through CHECK/FIRE/REFRAC: the held sum is taken exactly once.
        while (rdy[0] !== 1'b1) @(negedge clk);
        s_in[0] = 10'd600;
        s_c[0]  = 1'b0;
        s_v[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_model[0] = model_step(m_model[0], 600);
        check("hold_mem_first", mo[0], m_model[0]);
        s_in[0] = 10'd100;
        low = (rdy[0] == 1'b0) ? 1 : 0;
        while (low > 0 && low < 50) begin
            @(negedge clk);
            if (rdy[0] == 1'b1) break;
            low++;
        end
        check("hold_ready_low_cycles", low, 2 + rf[0]);
        @(posedge clk);
        @(negedge clk);
        s_v[0] = 1'b0;
        m_model[0] = model_step(0, 100);
        check("hold_accept_once", mo[0], m_model[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_no_duplicate", mo[0], m_model[0]);
        end
        check("hold_ready_back", rdy[0], 1);

        // Reset in the first refractory cycle while the spike is high.
        send(0, 400);
        s_in[0] = 10'd200;
        s_c[0]  = 1'b0;
        s_v[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_spike", spk[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_mem", mo[0], 0);
        check("async_reset_spike", spk[0], 0);
        check("async_reset_ready", rdy[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        m_model[0] = 0;
        m_model[1] = 0;
        @(negedge clk);
        check("post_reset_ready", rdy[0], 1);
        check("post_reset_mem", mo[0], 0);
        check("post_reset_spike", spk[0], 0);

        // Randomised integrations against the model.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) == 0) val = int'($urandom_range(0, 2047));
            else val = int'($urandom_range(0, 300));
            send(0, val);
        end

        // Saturation at full scale with THRESH=65535 and no refractory period.
        for (int n = 0; n < 33; n++) send(1, 2047);
        send(1, 2047);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
